// File: rtl/aes_gcm_ghash_engine.sv
// rtl/aes_gcm_ghash_engine.sv - GCM GHASH accumulator and tag generator with digit-serial GF(2^128) multiply
//
// Purpose: absorbs AAD blocks and then CT blocks over a valid/ready handshake.
// Each block is folded into S as S = (S ^ block) * H. The trailing partial
// blocks are zero-masked. After the last block, the length block is folded in
// the same way. The engine then emits tag = (S ^ E(K,J0))[0:TAG_W-1].
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   i_start          one-cycle pulse; latches i_h, i_encrypted_j0 and both lengths (idle only)
//   i_h              hash subkey H, GCM bit order [0:127]
//   i_encrypted_j0   E(K,J0), GCM bit order
//   i_aad_bits       AAD length in bits
//   i_ct_bits        ciphertext length in bits
//   i_valid          i_block valid
//   i_block          data block, AAD blocks first and then CT blocks
//   o_ready          engine takes i_block this cycle
//   o_busy           instance in progress
//   o_tag_valid      one-cycle tag strobe
//   o_tag            authentication tag [0:TAG_W-1]; holds until the next strobe
module aes_gcm_ghash_engine #(
   parameter int DIGIT_W = 8,
   parameter int LEN_W   = 39,
   parameter int TAG_W   = 128
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [0:127]     i_h,
   input  logic [0:127]     i_encrypted_j0,
   input  logic [LEN_W-1:0] i_aad_bits,
   input  logic [LEN_W-1:0] i_ct_bits,
   input  logic             i_valid,
   input  logic [0:127]     i_block,
   output logic             o_ready,
   output logic             o_busy,
   output logic             o_tag_valid,
   output logic [0:TAG_W-1] o_tag
);

   localparam int K     = 128 / DIGIT_W;
   localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
   localparam int BLK_W = LEN_W - 7;
   // Index 0 is the x^0 coefficient, so the reduction constant sits at the left end.
   localparam logic [0:127] R_POLY = {8'hE1, 120'h0};

   typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_MULT, S_LEN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [0:127]     h_q, h_d, ej0_q, ej0_d, len_q, len_d;
   logic [0:127]     s_q, s_d, x_q, x_d, z_q, z_d, v_q, v_d;
   logic [BLK_W-1:0] aad_rem_q, aad_rem_d, ct_rem_q, ct_rem_d;
   logic [6:0]       aad_r_q, aad_r_d, ct_r_q, ct_r_d;
   logic [CNT_W-1:0] dig_q, dig_d;
   logic             len_phase_q, len_phase_d;
   logic [0:TAG_W-1] tag_q, tag_d;

   logic [0:127]     z_step, v_step, blk_mask, blk_masked, tag_full;
   logic [BLK_W-1:0] na_calc, nc_calc;
   logic             is_aad, is_last;
   logic [6:0]       r_sel;

   // Datapath: one digit of the shift-and-add multiply, plus block masking.
   always_comb begin
      z_step = z_q;
      v_step = v_q;
      for (int i = 0; i < DIGIT_W; i++) begin
         if (x_q[i]) begin
            z_step = z_step ^ v_step;
         end
         // Multiplying V by x moves it one place right in GCM order.
         // A carry out of bit 127 folds back in through R.
         v_step = v_step[127] ? ((v_step >> 1) ^ R_POLY) : (v_step >> 1);
      end
      tag_full = z_step ^ ej0_q;

      na_calc = BLK_W'(i_aad_bits >> 7) + {{(BLK_W-1){1'b0}}, |i_aad_bits[6:0]};
      nc_calc = BLK_W'(i_ct_bits >> 7) + {{(BLK_W-1){1'b0}}, |i_ct_bits[6:0]};

      // While AAD blocks remain, the incoming block is AAD.
      is_aad  = (aad_rem_q != '0);
      r_sel   = is_aad ? aad_r_q : ct_r_q;
      is_last = is_aad ? (aad_rem_q == BLK_W'(1)) : (ct_rem_q == BLK_W'(1));
      blk_mask = '1;
      if (is_last && (r_sel != 7'd0)) begin
         blk_mask = ~({128{1'b1}} >> r_sel);
      end
      blk_masked = i_block & blk_mask;
   end

   always_comb begin
      state_d     = state_q;
      h_d         = h_q;
      ej0_d       = ej0_q;
      len_d       = len_q;
      s_d         = s_q;
      x_d         = x_q;
      z_d         = z_q;
      v_d         = v_q;
      aad_rem_d   = aad_rem_q;
      ct_rem_d    = ct_rem_q;
      aad_r_d     = aad_r_q;
      ct_r_d      = ct_r_q;
      dig_d       = dig_q;
      len_phase_d = len_phase_q;
      tag_d       = tag_q;

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               h_d         = i_h;
               ej0_d       = i_encrypted_j0;
               len_d       = {64'(i_aad_bits), 64'(i_ct_bits)};
               s_d         = '0;
               aad_rem_d   = na_calc;
               ct_rem_d    = nc_calc;
               aad_r_d     = i_aad_bits[6:0];
               ct_r_d      = i_ct_bits[6:0];
               len_phase_d = 1'b0;
               state_d     = ((na_calc != '0) || (nc_calc != '0)) ? S_ACCEPT : S_LEN;
            end
         end
         S_ACCEPT: begin
            if (i_valid) begin
               x_d   = s_q ^ blk_masked;
               z_d   = '0;
               v_d   = h_q;
               dig_d = '0;
               if (is_aad) begin
                  aad_rem_d = aad_rem_q - BLK_W'(1);
               end else begin
                  ct_rem_d = ct_rem_q - BLK_W'(1);
               end
               state_d = S_MULT;
            end
         end
         S_LEN: begin
            x_d         = s_q ^ len_q;
            z_d         = '0;
            v_d         = h_q;
            dig_d       = '0;
            len_phase_d = 1'b1;
            state_d     = S_MULT;
         end
         S_MULT: begin
            z_d   = z_step;
            v_d   = v_step;
            x_d   = x_q << DIGIT_W;
            dig_d = dig_q + CNT_W'(1);
            if (dig_q == CNT_W'(K - 1)) begin
               s_d = z_step;
               if (len_phase_q) begin
                  // Loaded on entry to DONE so the tag is stable during the strobe.
                  tag_d   = tag_full[0:TAG_W-1];
                  state_d = S_DONE;
               end else if ((aad_rem_q != '0) || (ct_rem_q != '0)) begin
                  state_d = S_ACCEPT;
               end else begin
                  state_d = S_LEN;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         h_q         <= '0;
         ej0_q       <= '0;
         len_q       <= '0;
         s_q         <= '0;
         x_q         <= '0;
         z_q         <= '0;
         v_q         <= '0;
         aad_rem_q   <= '0;
         ct_rem_q    <= '0;
         aad_r_q     <= '0;
         ct_r_q      <= '0;
         dig_q       <= '0;
         len_phase_q <= 1'b0;
         tag_q       <= '0;
      end else begin
         state_q     <= state_d;
         h_q         <= h_d;
         ej0_q       <= ej0_d;
         len_q       <= len_d;
         s_q         <= s_d;
         x_q         <= x_d;
         z_q         <= z_d;
         v_q         <= v_d;
         aad_rem_q   <= aad_rem_d;
         ct_rem_q    <= ct_rem_d;
         aad_r_q     <= aad_r_d;
         ct_r_q      <= ct_r_d;
         dig_q       <= dig_d;
         len_phase_q <= len_phase_d;
         tag_q       <= tag_d;
      end
   end

   assign o_ready     = (state_q == S_ACCEPT);
   assign o_busy      = (state_q != S_IDLE);
   assign o_tag_valid = (state_q == S_DONE);
   assign o_tag       = tag_q;

endmodule

// File: tb/tb_aes_gcm_ghash_engine.sv
// tb/tb_aes_gcm_ghash_engine.sv - self-checking bench for aes_gcm_ghash_engine
module tb_aes_gcm_ghash_engine;

   localparam logic [0:127] NIST_H   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
   localparam logic [0:127] NIST_EJ0 = 128'h58e2fccefa7e3061367f1d57a4e7455a;
   localparam logic [0:127] NIST_C   = 128'h0388dace60b6a392f328c2b971b2fe78;
   localparam logic [0:127] NIST_T2  = 128'hab6e47d42cec13bdf53a67b21257bddf;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic         start [3];
   logic [0:127] h     [3];
   logic [0:127] ej0   [3];
   logic [38:0]  aadb  [3];
   logic [38:0]  ctb   [3];
   logic         vld   [3];
   logic [0:127] blk   [3];
   logic         rdy   [3];
   logic         busy  [3];
   logic         tv    [3];
   logic [0:127] tag0, tag1;
   logic [0:95]  tag2;

   // dut0: K=1, dut1: K=16, dut2: K=8 with a 96-bit tag
   aes_gcm_ghash_engine #(.DIGIT_W(128)) dut0 (
      .clk(clk), .rst_n(rst_n), .i_start(start[0]), .i_h(h[0]), .i_encrypted_j0(ej0[0]),
      .i_aad_bits(aadb[0]), .i_ct_bits(ctb[0]), .i_valid(vld[0]), .i_block(blk[0]),
      .o_ready(rdy[0]), .o_busy(busy[0]), .o_tag_valid(tv[0]), .o_tag(tag0));
   aes_gcm_ghash_engine #(.DIGIT_W(8)) dut1 (
      .clk(clk), .rst_n(rst_n), .i_start(start[1]), .i_h(h[1]), .i_encrypted_j0(ej0[1]),
      .i_aad_bits(aadb[1]), .i_ct_bits(ctb[1]), .i_valid(vld[1]), .i_block(blk[1]),
      .o_ready(rdy[1]), .o_busy(busy[1]), .o_tag_valid(tv[1]), .o_tag(tag1));
   aes_gcm_ghash_engine #(.DIGIT_W(16), .TAG_W(96)) dut2 (
      .clk(clk), .rst_n(rst_n), .i_start(start[2]), .i_h(h[2]), .i_encrypted_j0(ej0[2]),
      .i_aad_bits(aadb[2]), .i_ct_bits(ctb[2]), .i_valid(vld[2]), .i_block(blk[2]),
      .o_ready(rdy[2]), .o_busy(busy[2]), .o_tag_valid(tv[2]), .o_tag(tag2));

   int n_cmp = 0;
   int n_bad = 0;
   logic [0:127] blk_buf [8];

   typedef struct {
      int           d;
      logic [0:127] h;
      logic [0:127] ej;
      logic [38:0]  ab;
      logic [38:0]  cb;
      int           nblk;
      logic [0:127] b0;
      logic [0:127] tag;
      int           lat;
      bit           use_model;
   } vec_t;

   vec_t vec [6];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_ne(input string nm, input logic [127:0] act, input logic [127:0] avoid);
      n_cmp++;
      if (act === avoid) begin
         n_bad++;
         $display("FAIL %s: got %h which must differ from %h", nm, act, avoid);
      end
   endtask

   function automatic logic [0:127] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic int kof(input int d);
      return (d == 0) ? 1 : ((d == 1) ? 16 : 8);
   endfunction

   function automatic logic [0:127] tmask(input int d);
      return (d == 2) ? {{96{1'b1}}, 32'h0} : {128{1'b1}};
   endfunction

   function automatic logic [0:127] tag_of(input int d);
      if (d == 0) return tag0;
      if (d == 1) return tag1;
      return {tag2, 32'h0};
   endfunction

   // Bit i is the coefficient of x^i: carry-less product, then fold x^128 = 1 + x + x^2 + x^7.
   function automatic logic [0:127] gf_mul(input logic [0:127] a, input logic [0:127] b);
      logic [0:254] p;
      p = '0;
      for (int i = 0; i < 128; i++)
         for (int j = 0; j < 128; j++)
            p[i+j] = p[i+j] ^ (a[i] & b[j]);
      for (int k = 254; k >= 128; k--) begin
         if (p[k]) begin
            p[k]     = 1'b0;
            p[k-128] = ~p[k-128];
            p[k-127] = ~p[k-127];
            p[k-126] = ~p[k-126];
            p[k-121] = ~p[k-121];
         end
      end
      return p[0:127];
   endfunction

   function automatic logic [0:127] model_tag(input logic [0:127] hh, input logic [0:127] ej,
                                              input longint ab, input longint cb);
      longint na, nc;
      logic [0:127] s, x, l;
      na = (ab + 127) / 128;
      nc = (cb + 127) / 128;
      s  = '0;
      for (int b = 0; b < int'(na + nc); b++) begin
         x = blk_buf[b];
         for (int j = 0; j < 128; j++) begin
            if (b < na) begin
               if (longint'(b) * 128 + j >= ab) x[j] = 1'b0;
            end else begin
               if ((longint'(b) - na) * 128 + j >= cb) x[j] = 1'b0;
            end
         end
         s = gf_mul(s ^ x, hh);
      end
      l = {64'(ab), 64'(cb)};
      s = gf_mul(s ^ l, hh);
      return s ^ ej;
   endfunction

   // Starts at a negedge, pulses i_start, then streams blk_buf and watches for the tag.
   task automatic run_inst(input int d, input logic [0:127] hh, input logic [0:127] ej,
                           input logic [38:0] ab, input logic [38:0] cb, input int nblk,
                           input int stall_pct, input int poke_cyc, input bit done_poke,
                           input int tail, output logic [0:127] tg, output int lat,
                           output int pulses, output bit rdy_seen);
      int  bi, cyc, after;
      bit  seen;
      h[d] = hh; ej0[d] = ej; aadb[d] = ab; ctb[d] = cb; start[d] = 1'b1; vld[d] = 1'b0;
      bi = 0; pulses = 0; lat = -1; rdy_seen = 1'b0; tg = '0; seen = 1'b0; after = 0;
      @(posedge clk);
      @(negedge clk);
      start[d] = 1'b0;
      h[d] = rand128(); ej0[d] = rand128();
      aadb[d] = 39'($urandom_range(0, 600)); ctb[d] = 39'($urandom_range(0, 600));
      cyc = 1;
      while (cyc < 3000) begin
         if (cyc == 1) chk($sformatf("busy_c1_d%0d", d), 128'(busy[d]), 128'(1));
         if (tv[d]) begin
            pulses++;
            if (!seen) begin
               seen = 1'b1;
               lat  = cyc;
               tg   = tag_of(d);
            end
         end
         if (rdy[d]) rdy_seen = 1'b1;
         if (seen) begin
            if (after == tail) break;
            after++;
         end
         start[d] = (cyc == poke_cyc) || (done_poke && tv[d]);
         if ((bi < nblk) && (int'($urandom_range(0, 99)) >= stall_pct)) begin
            vld[d] = 1'b1;
            blk[d] = blk_buf[bi];
            if (rdy[d]) bi++;
         end else begin
            vld[d] = 1'b0;
            blk[d] = rand128();
         end
         @(negedge clk);
         cyc++;
      end
      if (!seen) $display("FAIL timeout_d%0d: no tag after %0d cycles, expected one", d, cyc);
      start[d] = 1'b0;
      vld[d]   = 1'b0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [0:127] tg, exp, unmasked;
      logic [0:127] tags [6];
      int lat, pulses, d, na, nc, stall, ab, cb, cnt;
      bit rs;

      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         start[i] = 1'b0; h[i] = '0; ej0[i] = '0; aadb[i] = '0; ctb[i] = '0;
         vld[i] = 1'b0; blk[i] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_busy_d%0d", i), 128'(busy[i]), 128'(0));
         chk($sformatf("rst_ready_d%0d", i), 128'(rdy[i]), 128'(0));
         chk($sformatf("rst_tv_d%0d", i), 128'(tv[i]), 128'(0));
         chk($sformatf("rst_tag_d%0d", i), tag_of(i), 128'(0));
      end
      rst_n = 1'b1;

      // d, H, EJ0, aad_bits, ct_bits, nblk, block, tag, latency, use_model
      vec[0] = '{0, NIST_H, NIST_EJ0, 39'd0, 39'd0,   0, 128'h0, NIST_EJ0, 3, 1'b0};
      vec[1] = '{1, NIST_H, NIST_EJ0, 39'd0, 39'd128, 1, NIST_C, NIST_T2, 35, 1'b0};
      vec[2] = '{1, NIST_H, NIST_EJ0, 39'd0, 39'd100, 1, NIST_C | ({128{1'b1}} >> 100),
                 128'h0, 35, 1'b1};
      vec[3] = '{2, NIST_H, NIST_EJ0, 39'd0, 39'd0,   0, 128'h0, NIST_EJ0, 10, 1'b0};
      vec[4] = '{2, NIST_H, NIST_EJ0, 39'd0, 39'd128, 1, NIST_C, NIST_T2, 19, 1'b0};
      vec[5] = '{0, NIST_H, NIST_EJ0, 39'd0, 39'd128, 1, NIST_C, NIST_T2, 5, 1'b0};

      for (int i = 0; i < 6; i++) begin
         blk_buf[0] = vec[i].b0;
         if (vec[i].use_model) begin
            blk_buf[0] = NIST_C & ~({128{1'b1}} >> 100);
            exp = model_tag(vec[i].h, vec[i].ej, longint'(vec[i].ab), longint'(vec[i].cb));
            blk_buf[0] = vec[i].b0;
         end else begin
            exp = vec[i].tag;
         end
         run_inst(vec[i].d, vec[i].h, vec[i].ej, vec[i].ab, vec[i].cb, vec[i].nblk,
                  0, -1, 1'b0, 4, tg, lat, pulses, rs);
         tags[i] = tg;
         chk($sformatf("vec%0d_tag", i), tg & tmask(vec[i].d), exp & tmask(vec[i].d));
         chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(vec[i].lat));
         chk($sformatf("vec%0d_pulses", i), 128'(pulses), 128'(1));
         chk($sformatf("vec%0d_ready_seen", i), 128'(rs), 128'(vec[i].nblk > 0));
      end

      // Partial block: the result must not match a run where the tail bits were hashed.
      unmasked = gf_mul(gf_mul(vec[2].b0, NIST_H) ^ {64'd0, 64'd100}, NIST_H) ^ NIST_EJ0;
      chk_ne("partial_vs_unmasked", tags[2], unmasked);

      // Randomized instances against the model.
      for (int r = 0; r < 6; r++) begin
         d     = 1 + (r % 2);
         ab    = (r == 0) ? 256 : int'($urandom_range(0, 300));
         cb    = (r == 0) ? 384 : int'($urandom_range(0, 300));
         stall = (r < 3) ? 0 : 30;
         na    = (ab + 127) / 128;
         nc    = (cb + 127) / 128;
         for (int b = 0; b < 8; b++) blk_buf[b] = rand128();
         h[d] = rand128();
         tg   = rand128();
         exp  = model_tag(h[d], tg, longint'(ab), longint'(cb));
         run_inst(d, h[d], tg, 39'(ab), 39'(cb), na + nc, stall, -1, 1'b0, 4,
                  tg, lat, pulses, rs);
         chk($sformatf("rand%0d_tag", r), tg & tmask(d), exp & tmask(d));
         chk($sformatf("rand%0d_pulses", r), 128'(pulses), 128'(1));
         if (stall == 0)
            chk($sformatf("rand%0d_latency", r), 128'(lat),
                128'(1 + (na + nc) * (kof(d) + 1) + (kof(d) + 1)));
      end

      // Backpressure with a stray i_start mid-instance.
      for (int b = 0; b < 8; b++) blk_buf[b] = rand128();
      exp = model_tag(NIST_H, NIST_EJ0, 128, 200);
      run_inst(1, NIST_H, NIST_EJ0, 39'd128, 39'd200, 3, 50, 7, 1'b0, 6, tg, lat, pulses, rs);
      chk("bp_tag", tg, exp);
      chk("bp_pulses", 128'(pulses), 128'(1));

      // Reset during MULT abandons the instance.
      h[1] = NIST_H; ej0[1] = NIST_EJ0; aadb[1] = 39'd0; ctb[1] = 39'd128;
      blk[1] = NIST_C; vld[1] = 1'b1; start[1] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start[1] = 1'b0;
      @(negedge clk);
      vld[1] = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_rst_in_mult", 128'({busy[1], rdy[1]}), 128'(2'b10));
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("post_rst_busy", 128'(busy[1]), 128'(0));
      chk("post_rst_ready", 128'(rdy[1]), 128'(0));
      chk("post_rst_tv", 128'(tv[1]), 128'(0));
      chk("post_rst_tag", tag1, 128'(0));
      cnt = 0;
      repeat (60) begin
         @(negedge clk);
         if (tv[1]) cnt++;
      end
      chk("aborted_no_tag", 128'(cnt), 128'(0));
      blk_buf[0] = NIST_C;
      run_inst(1, NIST_H, NIST_EJ0, 39'd0, 39'd128, 1, 0, -1, 1'b0, 4, tg, lat, pulses, rs);
      chk("after_rst_tag", tg, NIST_T2);
      chk("after_rst_latency", 128'(lat), 128'(35));

      // Back-to-back on the 96-bit build; a start during DONE must be dropped.
      run_inst(2, NIST_H, NIST_EJ0, 39'd0, 39'd0, 0, 0, -1, 1'b1, 1, tg, lat, pulses, rs);
      chk("b2b_first_tag", tg & tmask(2), NIST_EJ0 & tmask(2));
      chk("b2b_first_latency", 128'(lat), 128'(10));
      blk_buf[0] = NIST_C;
      run_inst(2, NIST_H, NIST_EJ0, 39'd0, 39'd128, 1, 0, -1, 1'b0, 4, tg, lat, pulses, rs);
      chk("b2b_second_tag", tg & tmask(2), NIST_T2 & tmask(2));
      chk("b2b_second_latency", 128'(lat), 128'(19));
      chk("b2b_second_pulses", 128'(pulses), 128'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
